// File: rtl/mem_block_responder_if.sv
// Cache-to-memory block port: level-held read/evict requests from the
// cache (master) and one-cycle response/acknowledge pulses from memory (slave).
interface mem_block_responder_if #(
  parameter int unsigned BLOCK_BITS = 512
);
  logic                  req_i;
  logic [31:0]           req_addr_i;
  logic                  resp_valid_o;
  logic [BLOCK_BITS-1:0] resp_data_o;
  logic [31:0]           resp_addr_o;
  logic                  evict_req_i;
  logic [31:0]           evict_addr_i;
  logic [BLOCK_BITS-1:0] evict_data_i;
  logic                  evict_ack_o;
  logic                  err_o;

  modport master (
    output req_i, req_addr_i, evict_req_i, evict_addr_i, evict_data_i,
    input  resp_valid_o, resp_data_o, resp_addr_o, evict_ack_o, err_o
  );

  modport slave (
    input  req_i, req_addr_i, evict_req_i, evict_addr_i, evict_data_i,
    output resp_valid_o, resp_data_o, resp_addr_o, evict_ack_o, err_o
  );
endinterface

// File: rtl/mem_block_responder.sv
// Block-granular backing memory for the cache's upper port. Serves one
// level-held read or evict at a time with fixed latencies; evict has priority.
// Optional feature macro: MEMRESP_BOUNDS_CHECK_EN (flags out-of-range addresses).
module mem_block_responder #(
  parameter int unsigned BLOCK_BITS    = 512,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mem_block_responder_if.slave bus
);

  localparam int unsigned IDX_BITS = $clog2(DEPTH);
  localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_BITS = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK} state_t;

  state_t                state, state_next;
  logic [CNT_BITS-1:0]   count, count_next;
  logic                  cap_rd, cap_wr;
  logic [31:0]           rd_addr, wr_addr;
  logic [BLOCK_BITS-1:0] wr_data;
  logic [31:0]           rd_sel_addr;
  logic [IDX_BITS-1:0]   rd_idx, wr_idx;
  logic                  rd_oob, wr_oob;
  logic [BLOCK_BITS-1:0] resp_data;
  logic [31:0]           resp_addr;
  logic [BLOCK_BITS-1:0] mem [DEPTH];

  // Address used for the response load: the live request on the accepting
  // cycle (READ_LATENCY=1), otherwise the captured one.
  assign rd_sel_addr = cap_rd ? bus.req_addr_i : rd_addr;
  assign rd_idx      = rd_sel_addr[IDX_BITS+5:6];
  assign wr_idx      = wr_addr[IDX_BITS+5:6];

  // State, counter and request capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (cap_rd) rd_addr <= bus.req_addr_i;
      if (cap_wr) begin
        wr_addr <= bus.evict_addr_i;
        wr_data <= bus.evict_data_i;
      end
    end
  end

  // Next-state, latency countdown and capture enables.
  always_comb begin
    state_next = state;
    count_next = count;
    cap_rd     = 1'b0;
    cap_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.evict_req_i) begin
          cap_wr     = 1'b1;
          count_next = WR_LOAD;
          state_next = (WRITE_LATENCY == 1) ? WR_ACK : WR_WAIT;
        end else if (bus.req_i) begin
          cap_rd     = 1'b1;
          count_next = RD_LOAD;
          state_next = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        count_next = count - CNT_BITS'(1);
        if (count_next == '0) state_next = RD_RESP;
      end
      RD_RESP: state_next = IDLE;
      WR_WAIT: begin
        count_next = count - CNT_BITS'(1);
        if (count_next == '0) state_next = WR_ACK;
      end
      WR_ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response registers load on the edge entering RD_RESP; the array cannot
  // change in between (writes only happen in WR_ACK), so this equals a read
  // in RD_RESP while keeping resp_data_o registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_data <= '0;
      resp_addr <= '0;
    end else if (state_next == RD_RESP) begin
      resp_data <= rd_oob ? '0 : mem[rd_idx];
      resp_addr <= {rd_sel_addr[31:6], 6'b0};
    end
  end

  // Commit the evicted block at the end of the ack cycle; reset drops it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == WR_ACK && !wr_oob) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign bus.resp_valid_o = (state == RD_RESP);
  assign bus.evict_ack_o  = (state == WR_ACK);
  assign bus.resp_data_o  = resp_data;
  assign bus.resp_addr_o  = resp_addr;

`ifdef MEMRESP_BOUNDS_CHECK_EN
  localparam logic [31:0] HI_MASK = ~((32'd1 << (IDX_BITS + 6)) - 32'd1);

  logic [31:0] wr_sel_addr;
  logic        wr_sel_oob;
  logic        err;

  assign wr_sel_addr = cap_wr ? bus.evict_addr_i : wr_addr;
  assign rd_oob      = |(rd_sel_addr & HI_MASK);
  assign wr_oob      = |(wr_addr & HI_MASK);
  assign wr_sel_oob  = |(wr_sel_addr & HI_MASK);

  // Error flag is registered so it coincides exactly with the pulse cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) err <= 1'b0;
    else       err <= ((state_next == RD_RESP) && rd_oob) ||
                      ((state_next == WR_ACK) && wr_sel_oob);
  end

  assign bus.err_o = err;
`else
  assign rd_oob    = 1'b0;
  assign wr_oob    = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // Offset and upper address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{rd_sel_addr, wr_addr};

endmodule
